// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and control bundle for the pipeline control path
package pipe_ctrl_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;
  localparam logic [2:0] ALU_MOV = 3'd5;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  localparam logic [1:0] REGSRC_DP  = 2'b00;
  localparam logic [1:0] REGSRC_BR  = 2'b01;
  localparam logic [1:0] REGSRC_STR = 2'b10;

  // alu_control is sized for the widest ALU; the top slices it to ALUCTRL_W
  typedef struct packed {
    logic       reg_write;
    logic       memto_reg;
    logic       mem_write;
    logic       branch;
    logic       pc_src;
    logic       alu_src;
    logic [1:0] flag_write;
    logic [2:0] alu_control;
    logic [3:0] cond;
  } ctrl_t;

endpackage

// File: rtl/pipe_cond_eval.sv
// rtl/pipe_cond_eval.sv - combinational evaluation of the 16 ARM condition codes against NZCV
module pipe_cond_eval
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_hz.sv
// rtl/pipe_ctrl_hz.sv - D/E/M/W control path with condition flags and hazard-unit hooks
// Optional BRANCH_EARLY_EN: taken branches redirect in E via BranchTakenE instead of PCSrcW.
module pipe_ctrl_hz
  import pipe_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 2,
  parameter int FLAG_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           Cond,
  input  logic [15:0]          Instr,
  input  logic [FLAG_W-1:0]    ALUFlags,
  input  logic                 StallE,
  input  logic                 FlushE,
  output logic [1:0]           RegSrcD,
  output logic [1:0]           ImmSrcD,
  output logic                 ALUSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 MemtoRegE,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic                 PCSrcW,
  output logic                 PCWrPendingF
`ifdef BRANCH_EARLY_EN
  ,
  output logic                 BranchTakenE
`endif
);

  ctrl_t             ctrl_d, de_q;
  logic [1:0]        op;
  logic [3:0]        cmd;
  logic              arith, decoded, s_bit;
  logic              cond_ex_e;
  logic [FLAG_W-1:0] flags_q;
  logic              pc_src_m, memto_reg_m;
  logic              unused_bits;

  // Instr carries bits [27:12]: op [15:14], I [13], cmd [12:9], S/L [8], Rd [3:0]
  assign op  = Instr[15:14];
  assign cmd = Instr[12:9];

  always_comb begin
    ctrl_d  = '0;
    RegSrcD = REGSRC_DP;
    ImmSrcD = IMM_8;
    arith   = 1'b0;
    decoded = 1'b0;
    s_bit   = Instr[8];
    case (op)
      2'b00: begin
        ctrl_d.alu_src   = Instr[13];
        ctrl_d.reg_write = 1'b1;
        decoded          = 1'b1;
        case (cmd)
          4'b0100: begin ctrl_d.alu_control = ALU_ADD; arith = 1'b1; end
          4'b0010: begin ctrl_d.alu_control = ALU_SUB; arith = 1'b1; end
          4'b0000: ctrl_d.alu_control = ALU_AND;
          4'b1100: ctrl_d.alu_control = ALU_ORR;
          default: begin
            decoded = 1'b0;
            if (ALUCTRL_W >= 3) begin
              decoded = 1'b1;
              case (cmd)
                4'b0001: ctrl_d.alu_control = ALU_EOR;
                4'b1101: ctrl_d.alu_control = ALU_MOV;
                4'b1010: begin
                  ctrl_d.alu_control = ALU_SUB;
                  ctrl_d.reg_write   = 1'b0;
                  arith              = 1'b1;
                  s_bit              = 1'b1;
                end
                default: decoded = 1'b0;
              endcase
            end
          end
        endcase
        if (decoded) ctrl_d.flag_write = s_bit ? (arith ? 2'b11 : 2'b10) : 2'b00;
        else         ctrl_d.reg_write  = 1'b0;
      end
      2'b01: begin
        ctrl_d.alu_src     = 1'b1;
        ImmSrcD            = IMM_12;
        ctrl_d.alu_control = Instr[11] ? ALU_ADD : ALU_SUB;
        if (Instr[8]) begin
          ctrl_d.reg_write = 1'b1;
          ctrl_d.memto_reg = 1'b1;
        end else begin
          ctrl_d.mem_write = 1'b1;
          RegSrcD          = REGSRC_STR;
        end
      end
      2'b10: begin
        ctrl_d.branch      = 1'b1;
        ctrl_d.alu_src     = 1'b1;
        ctrl_d.alu_control = ALU_ADD;
        ImmSrcD            = IMM_24;
        RegSrcD            = REGSRC_BR;
      end
      default: ;
    endcase
    ctrl_d.cond = Cond;
`ifdef BRANCH_EARLY_EN
    ctrl_d.pc_src = (Instr[3:0] == 4'hF) & ctrl_d.reg_write;
`else
    ctrl_d.pc_src = ((Instr[3:0] == 4'hF) & ctrl_d.reg_write) | ctrl_d.branch;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset || FlushE) de_q <= '0;
    else if (!StallE)    de_q <= ctrl_d;
  end

  pipe_cond_eval u_cond_eval (
    .cond    (de_q.cond),
    .flags   (flags_q[3:0]),
    .cond_ex (cond_ex_e)
  );

  // A stalled E instruction has not completed, so it must not commit flags yet
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else if (cond_ex_e && !StallE) begin
      if (de_q.flag_write[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (de_q.flag_write[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || StallE) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      memto_reg_m <= 1'b0;
      pc_src_m    <= 1'b0;
    end else begin
      RegWriteM   <= de_q.reg_write & cond_ex_e;
      MemWriteM   <= de_q.mem_write & cond_ex_e;
      memto_reg_m <= de_q.memto_reg;
      pc_src_m    <= de_q.pc_src & cond_ex_e;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      PCSrcW    <= 1'b0;
    end else begin
      RegWriteW <= RegWriteM;
      MemtoRegW <= memto_reg_m;
      PCSrcW    <= pc_src_m;
    end
  end

  assign ALUSrcE      = de_q.alu_src;
  assign ALUControlE  = de_q.alu_control[ALUCTRL_W-1:0];
  assign MemtoRegE    = de_q.memto_reg;
  assign PCWrPendingF = ctrl_d.pc_src | (de_q.pc_src & cond_ex_e) | pc_src_m;
`ifdef BRANCH_EARLY_EN
  assign BranchTakenE = de_q.branch & cond_ex_e;
`endif

  assign unused_bits = ^{Instr[7:4], de_q.alu_control, de_q.branch};

endmodule

// File: tb/tb_pipe_ctrl_hz.sv
// tb/tb_pipe_ctrl_hz.sv - directed and randomized checks of pipe_ctrl_hz against an instruction-level model
module tb_pipe_ctrl_hz;

  localparam int AW = 3;
  localparam logic [3:0] AL = 4'hE;
  localparam logic [15:0] NOP = 16'hC000;
`ifdef BRANCH_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, StallE, FlushE;
  logic [3:0]    Cond, ALUFlags;
  logic [15:0]   Instr;
  logic [1:0]    RegSrcD, ImmSrcD;
  logic          ALUSrcE, MemtoRegE, RegWriteM, MemWriteM, RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF;
  logic [AW-1:0] ALUControlE;
`ifdef BRANCH_EARLY_EN
  logic          BranchTakenE;
`endif

  pipe_ctrl_hz #(.ALUCTRL_W(AW), .FLAG_W(4)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Instr(Instr), .ALUFlags(ALUFlags),
    .StallE(StallE), .FlushE(FlushE), .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .MemtoRegE(MemtoRegE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .RegWriteW(RegWriteW),
    .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .PCWrPendingF(PCWrPendingF)
`ifdef BRANCH_EARLY_EN
    , .BranchTakenE(BranchTakenE)
`endif
  );

  typedef struct packed {
    logic       rw, ld, mw, br, pc, alusrc, alu_dc;
    logic [1:0] fw, regsrc, immsrc;
    logic [2:0] alu;
    logic [3:0] cond;
  } rec_t;

  rec_t       e_s;
  logic       m_rw, m_mw, m_ld, m_pc, w_rw, w_ld, w_pc;
  logic [3:0] flags_m;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    if (c == 4'd14) return 1'b1;
    if (c == 4'd15) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      default: base = ~z & (n == v);
    endcase
    return base ^ c[0];
  endfunction

  function automatic rec_t decode(input logic [3:0] c, input logic [15:0] i);
    rec_t r;
    int code;
    bit arith, cmp;
    r = '0;
    code = -1; arith = 0; cmp = 0;
    case (i[15:14])
      2'd0: begin
        case (i[12:9])
          4'd4:  begin code = 0; arith = 1; end
          4'd2:  begin code = 1; arith = 1; end
          4'd0:  code = 2;
          4'd12: code = 3;
          4'd1:  if (AW >= 3) code = 4;
          4'd13: if (AW >= 3) code = 5;
          4'd10: if (AW >= 3) begin code = 1; arith = 1; cmp = 1; end
          default: code = -1;
        endcase
        r.alusrc = i[13];
        if (code >= 0) begin
          r.alu = 3'(code);
          r.rw  = !cmp;
          r.fw  = (i[8] || cmp) ? (arith ? 2'b11 : 2'b10) : 2'b00;
        end else begin
          r.alu_dc = 1'b1;
        end
      end
      2'd1: begin
        r.alusrc = 1'b1; r.immsrc = 2'b01;
        r.alu = i[11] ? 3'd0 : 3'd1;
        if (i[8]) begin r.rw = 1'b1; r.ld = 1'b1; end
        else begin r.mw = 1'b1; r.regsrc = 2'b10; end
      end
      2'd2: begin
        r.br = 1'b1; r.alusrc = 1'b1; r.immsrc = 2'b10; r.regsrc = 2'b01;
      end
      default: ;
    endcase
    r.pc   = (r.rw && i[3:0] == 4'hF) || (r.br && !EARLY);
    r.cond = c;
    return r;
  endfunction

  task automatic check_outputs();
    rec_t d;
    logic ok;
    d  = decode(Cond, Instr);
    ok = cond_ok(e_s.cond, flags_m);
    check_eq("RegSrcD", 8'(RegSrcD), 8'(d.regsrc));
    check_eq("ImmSrcD", 8'(ImmSrcD), 8'(d.immsrc));
    check_eq("ALUSrcE", 8'(ALUSrcE), 8'(e_s.alusrc));
    if (!e_s.alu_dc) check_eq("ALUControlE", 8'(ALUControlE), 8'(e_s.alu));
    check_eq("MemtoRegE", 8'(MemtoRegE), 8'(e_s.ld));
    check_eq("RegWriteM", 8'(RegWriteM), 8'(m_rw));
    check_eq("MemWriteM", 8'(MemWriteM), 8'(m_mw));
    check_eq("RegWriteW", 8'(RegWriteW), 8'(w_rw));
    check_eq("MemtoRegW", 8'(MemtoRegW), 8'(w_ld));
    check_eq("PCSrcW", 8'(PCSrcW), 8'(w_pc));
    check_eq("PCWrPendingF", 8'(PCWrPendingF), 8'(d.pc | (e_s.pc & ok) | m_pc));
`ifdef BRANCH_EARLY_EN
    check_eq("BranchTakenE", 8'(BranchTakenE), 8'(e_s.br & ok));
`endif
    check_eq("Flags", 8'(dut.flags_q), 8'(flags_m));
  endtask

  task automatic model_update();
    logic ok;
    if (reset) begin
      e_s = '0; flags_m = '0;
      {m_rw, m_mw, m_ld, m_pc, w_rw, w_ld, w_pc} = '0;
    end else begin
      ok = cond_ok(e_s.cond, flags_m);
      if (ok && !StallE) begin
        if (e_s.fw[1]) flags_m[3:2] = ALUFlags[3:2];
        if (e_s.fw[0]) flags_m[1:0] = ALUFlags[1:0];
      end
      w_rw = m_rw; w_ld = m_ld; w_pc = m_pc;
      if (StallE) {m_rw, m_mw, m_ld, m_pc} = '0;
      else begin
        m_rw = e_s.rw & ok; m_mw = e_s.mw & ok; m_ld = e_s.ld; m_pc = e_s.pc & ok;
      end
      if (FlushE)       e_s = '0;
      else if (!StallE) e_s = decode(Cond, Instr);
    end
  endtask

  task automatic step(input logic [3:0] c, input logic [15:0] i, input logic [3:0] af,
                      input logic st, input logic fl);
    Cond = c; Instr = i; ALUFlags = af; StallE = st; FlushE = fl;
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] dp(input logic imm, input logic [3:0] cmd, input logic s,
                                     input logic [3:0] rd);
    return {2'b00, imm, cmd, s, 4'h2, rd};
  endfunction

  function automatic logic [15:0] mem(input logic u, input logic l, input logic [3:0] rd);
    return {2'b01, 1'b0, 1'b1, u, 1'b0, 1'b0, l, 4'h3, rd};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  af_e, rd, cmds [8];
    logic [15:0] ins;
    int          cnt;
    cmds = '{4'd4, 4'd2, 4'd0, 4'd12, 4'd1, 4'd13, 4'd10, 4'd15};
    e_s = '0; flags_m = '0;
    {m_rw, m_mw, m_ld, m_pc, w_rw, w_ld, w_pc} = '0;
    reset = 1'b1; Cond = AL; Instr = NOP; ALUFlags = '0; StallE = 1'b0; FlushE = 1'b0;
    @(posedge clk); #1;
    step(AL, NOP, 4'h0, 0, 0);
    check_eq("rst_RegWriteW", 8'(RegWriteW), 8'd0);
    check_eq("rst_PCSrcW", 8'(PCSrcW), 8'd0);
    check_eq("rst_MemWriteM", 8'(MemWriteM), 8'd0);
    reset = 1'b0;

    step(AL, dp(1, 4'b0100, 0, 4'd1), 4'h0, 0, 0);
    check_eq("add_ALUSrcE", 8'(ALUSrcE), 8'd1);
    check_eq("add_ALUControlE", 8'(ALUControlE), 8'd0);
    step(AL, NOP, 4'h0, 0, 0);
    step(AL, NOP, 4'h0, 0, 0);
    check_eq("add_RegWriteW", 8'(RegWriteW), 8'd1);
    check_eq("add_PCSrcW", 8'(PCSrcW), 8'd0);

    for (int k = 0; k < 2; k++) begin
      af_e = (k == 0) ? 4'b0100 : 4'b0000;
      step(AL, dp(1, 4'b0010, 1, 4'd1), 4'h0, 0, 0);
      step(AL, NOP, af_e, 0, 0);
      check_eq("subs_Flags", 8'(dut.flags_q), 8'(af_e));
      step(4'b0000, dp(1, 4'b0100, 0, 4'd3), 4'h0, 0, 0);
      step(AL, NOP, 4'h0, 0, 0);
      step(AL, NOP, 4'h0, 0, 0);
      check_eq("addeq_RegWriteW", 8'(RegWriteW), 8'(k == 0));
    end

    step(AL, mem(1, 0, 4'd2), 4'h0, 0, 1);
    step(AL, NOP, 4'h0, 0, 0);
    check_eq("str_flush_MemWriteM", 8'(MemWriteM), 8'd0);
    step(AL, mem(1, 0, 4'd2), 4'h0, 0, 0);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step(AL, NOP, 4'h0, k < 2, 0);
      cnt += int'(MemWriteM);
    end
    check_eq("str_stall_count", 8'(cnt), 8'd1);

    reset = 1'b1; step(AL, NOP, 4'h0, 0, 0); reset = 1'b0;
    step(AL, dp(0, 4'b0000, 1, 4'd4), 4'h0, 0, 0);
    step(AL, NOP, 4'hF, 0, 0);
    check_eq("ands_Flags", 8'(dut.flags_q), 8'hC);

    step(AL, mem(1, 1, 4'd5), 4'h0, 0, 0);
    step(AL, NOP, 4'h0, 0, 0);
    reset = 1'b1; step(AL, NOP, 4'h0, 0, 0); reset = 1'b0;
    check_eq("ldr_rst_RegWriteW", 8'(RegWriteW), 8'd0);
    check_eq("ldr_rst_MemtoRegW", 8'(MemtoRegW), 8'd0);
    check_eq("ldr_rst_Flags", 8'(dut.flags_q), 8'd0);

    step(AL, dp(0, 4'b1010, 0, 4'd6), 4'h0, 0, 0);
    check_eq("cmp_ALUControlE", 8'(ALUControlE), 8'd1);
    step(AL, NOP, 4'b0011, 0, 0);
    check_eq("cmp_Flags", 8'(dut.flags_q), 8'h3);
    step(AL, NOP, 4'h0, 0, 0);
    check_eq("cmp_RegWriteW", 8'(RegWriteW), 8'd0);

    Cond = AL; Instr = {2'b10, 14'h2000}; #1;
    check_eq("b_pendD", 8'(PCWrPendingF), 8'(!EARLY));
    step(AL, {2'b10, 14'h2000}, 4'h0, 0, 0);
    Instr = NOP; #1;
    check_eq("b_pendE", 8'(PCWrPendingF), 8'(!EARLY));
`ifdef BRANCH_EARLY_EN
    check_eq("b_BranchTakenE", 8'(BranchTakenE), 8'd1);
`endif
    step(AL, NOP, 4'h0, 0, 0);
    check_eq("b_pendM", 8'(PCWrPendingF), 8'(!EARLY));
    step(AL, NOP, 4'h0, 0, 0);
    check_eq("b_PCSrcW", 8'(PCSrcW), 8'(!EARLY));

    for (int n = 0; n < 800; n++) begin
      rd = ($urandom % 4 == 0) ? 4'hF : 4'($urandom);
      case ($urandom % 4)
        0: ins = dp(1'($urandom), cmds[$urandom % 8], 1'($urandom), rd);
        1: ins = mem(1'($urandom), 1'($urandom), rd);
        2: ins = {2'b10, 14'($urandom)};
        default: ins = {2'b11, 14'($urandom)};
      endcase
      reset = ($urandom % 50 == 0);
      step(($urandom % 3 == 0) ? AL : 4'($urandom), ins, 4'($urandom),
           ($urandom % 8 == 0), ($urandom % 8 == 0));
    end
    reset = 1'b0;
    for (int n = 0; n < 4; n++) step(AL, NOP, 4'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
